// File: rtl/key_repeat_conditioner_if.sv
// Key channel bundle between raw inputs and game logic.
// Raw levels in; debounced levels and action pulses out.
interface key_repeat_conditioner_if #(
    parameter int N_KEYS = 4
);
    logic [N_KEYS-1:0] key_raw;
    logic [N_KEYS-1:0] key_level;
    logic [N_KEYS-1:0] key_pulse;
    logic              any_pulse;

    modport master (
        output key_raw,
        input  key_level,
        input  key_pulse,
        input  any_pulse
    );

    modport slave (
        input  key_raw,
        output key_level,
        output key_pulse,
        output any_pulse
    );
endinterface

// File: rtl/key_repeat_conditioner.sv
// Per-key synchroniser, debouncer and auto-repeat generator.
// Emits a pulse on press, then delayed repeats while held.
module key_repeat_conditioner #(
    parameter int              N_KEYS          = 4,
    parameter int              SYNC_STAGES     = 2,
    parameter int              DEBOUNCE_CYCLES = 16,
    parameter int              DAS_DELAY       = 64,
    parameter int              ARR_PERIOD      = 16,
    parameter logic [N_KEYS-1:0] REPEAT_MASK   = 4'b1011,
    parameter int              CNT_W           = 8
) (
    input logic clk,
    input logic reset,
    input logic clear,
    key_repeat_conditioner_if.slave bus
);
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    // Oversized parameters clamp to the counter ceiling.
    localparam int DB_M  = DEBOUNCE_CYCLES - 1;
    localparam int DAS_M = DAS_DELAY - 1;
    localparam int ARR_M = ARR_PERIOD - 1;

    localparam logic [CNT_W-1:0] DB_LAST =
        CNT_W'(DB_M > CNT_MAX ? CNT_MAX : DB_M);
    localparam logic [CNT_W-1:0] DAS_LAST =
        CNT_W'(DAS_M > CNT_MAX ? CNT_MAX : DAS_M);
    localparam logic [CNT_W-1:0] ARR_LAST =
        CNT_W'(ARR_M > CNT_MAX ? CNT_MAX : ARR_M);

    localparam bit PARAMS_LEGAL =
        SYNC_STAGES >= 2 &&
        DEBOUNCE_CYCLES >= 1 &&
        DAS_DELAY >= 2 &&
        ARR_PERIOD >= 1 &&
        DEBOUNCE_CYCLES <= CNT_MAX &&
        DAS_DELAY <= CNT_MAX &&
        ARR_PERIOD <= CNT_MAX;

    typedef enum logic [1:0] {
        IDLE,
        DELAY,
        REPEAT,
        HELD
    } state_t;

    logic [N_KEYS-1:0] sync_q [SYNC_STAGES];
    logic [N_KEYS-1:0] sync;
    logic [N_KEYS-1:0] level;
    logic [N_KEYS-1:0] pulse;
    logic [N_KEYS-1:0] pulse_nxt;
    logic              any_q;

    assign sync = sync_q[SYNC_STAGES-1];

    // Metastability chain for the asynchronous key levels.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int s = 0; s < SYNC_STAGES; s++)
                sync_q[s] <= '0;
        end else if (clear) begin
            for (int s = 0; s < SYNC_STAGES; s++)
                sync_q[s] <= '0;
        end else begin
            sync_q[0] <= bus.key_raw;
            for (int s = 1; s < SYNC_STAGES; s++)
                sync_q[s] <= sync_q[s-1];
        end
    end

    for (genvar i = 0; i < N_KEYS; i++) begin : g_key
        logic [CNT_W-1:0] cnt;
        logic [CNT_W-1:0] rcnt;
        logic             lvl;
        logic             lvl_nxt;
        logic             pnx;
        logic             pls;
        state_t           state;

        // Level flips once the mismatch has persisted long enough.
        always_comb begin
            lvl_nxt = lvl;
            if (sync[i] != lvl && cnt == DB_LAST)
                lvl_nxt = ~lvl;
        end

        // Debounce counter and accepted level.
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                cnt <= '0;
                lvl <= 1'b0;
            end else if (clear) begin
                cnt <= '0;
                lvl <= 1'b0;
            end else begin
                lvl <= lvl_nxt;
                if (sync[i] == lvl || cnt == DB_LAST)
                    cnt <= '0;
                else
                    cnt <= cnt + CNT_W'(1);
            end
        end

        // Pulse due at the coming edge; release suppresses it.
        always_comb begin
            pnx = 1'b0;
            if (!clear && lvl_nxt) begin
                unique case (state)
                    IDLE:   pnx = ~lvl;
                    DELAY:  pnx = (rcnt == DAS_LAST);
                    REPEAT: pnx = (rcnt == ARR_LAST);
                    HELD:   pnx = 1'b0;
                endcase
            end
        end

        // Press / delay / repeat sequencer.
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                state <= IDLE;
                rcnt  <= '0;
                pls   <= 1'b0;
            end else if (clear) begin
                state <= IDLE;
                rcnt  <= '0;
                pls   <= 1'b0;
            end else begin
                pls <= pnx;
                if (!lvl_nxt) begin
                    state <= IDLE;
                    rcnt  <= '0;
                end else begin
                    unique case (state)
                        IDLE: begin
                            rcnt <= '0;
                            if (REPEAT_MASK[i])
                                state <= DELAY;
                            else
                                state <= HELD;
                        end
                        DELAY: begin
                            if (rcnt == DAS_LAST) begin
                                state <= REPEAT;
                                rcnt  <= '0;
                            end else begin
                                rcnt <= rcnt + CNT_W'(1);
                            end
                        end
                        REPEAT: begin
                            if (rcnt == ARR_LAST)
                                rcnt <= '0;
                            else
                                rcnt <= rcnt + CNT_W'(1);
                        end
                        HELD: state <= HELD;
                    endcase
                end
            end
        end

        assign level[i]     = lvl;
        assign pulse[i]     = pls;
        assign pulse_nxt[i] = pnx;
    end

    // Summary pulse registered alongside the per-key pulses.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            any_q <= 1'b0;
        else if (clear)
            any_q <= 1'b0;
        else
            any_q <= |pulse_nxt;
    end

    assign bus.key_level = level;
    assign bus.key_pulse = pulse;
    assign bus.any_pulse = any_q;

    legal_params: assert property (@(posedge clk) PARAMS_LEGAL);

endmodule

// File: tb/tb_key_repeat_conditioner.sv
// Randomised bench with a timing-rule reference model
// plus directed literal checks of the key scenarios.
module tb_key_repeat_conditioner;
    localparam int N   = 4;
    localparam int SY  = 2;
    localparam int DB  = 4;
    localparam int DAS = 10;
    localparam int ARR = 3;
    localparam logic [3:0] MASK = 4'b1011;

    logic clk = 1'b0;
    logic reset;
    logic clear;

    key_repeat_conditioner_if #(.N_KEYS(N)) bus();

    key_repeat_conditioner #(
        .N_KEYS(N),
        .SYNC_STAGES(SY),
        .DEBOUNCE_CYCLES(DB),
        .DAS_DELAY(DAS),
        .ARR_PERIOD(ARR),
        .REPEAT_MASK(MASK),
        .CNT_W(8)
    ) dut (
        .clk(clk),
        .reset(reset),
        .clear(clear),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name,
                         input logic [31:0] got,
                         input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h want %0h",
                     name, got, want);
        end
    endtask

    // Model: hist[i][k] is the raw sample taken k edges ago.
    // Level flips when DB consecutive synchronised samples
    // disagree with it; pulses follow time-since-press.
    logic [7:0]   hist [N];
    logic [N-1:0] m_lvl;
    logic [N-1:0] m_pls;
    logic         m_any;
    int           age [N];

    always @(posedge clk) begin
        if (!reset || clear) begin
            for (int i = 0; i < N; i++) begin
                hist[i] = '0;
                age[i]  = 0;
            end
            m_lvl = '0;
            m_pls = '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                logic differ;
                logic nl;
                hist[i] = {hist[i][6:0], bus.key_raw[i]};
                differ = 1'b1;
                for (int k = SY; k < SY + DB; k++)
                    if (hist[i][k] == m_lvl[i])
                        differ = 1'b0;
                nl = m_lvl[i] ^ differ;
                if (nl && !m_lvl[i]) begin
                    age[i]   = 0;
                    m_pls[i] = 1'b1;
                end else if (nl) begin
                    age[i]   = age[i] + 1;
                    m_pls[i] = MASK[i] && age[i] >= DAS &&
                               (age[i] - DAS) % ARR == 0;
                end else begin
                    m_pls[i] = 1'b0;
                end
                m_lvl[i] = nl;
            end
        end
        m_any = |m_pls;
        #1;
        check("level", 32'(bus.key_level), 32'(m_lvl));
        check("pulse", 32'(bus.key_pulse), 32'(m_pls));
        check("any",   32'(bus.any_pulse), 32'(m_any));
    end

    int pt[$];
    int fall_at;

    function automatic int pt_at(input int idx);
        return (pt.size() > idx) ? pt[idx] : -1;
    endfunction

    // Hold one key for `hold` edges, log pulse edge numbers.
    task automatic hold_key(input int key,
                            input int hold,
                            input int total);
        pt.delete();
        fall_at = -1;
        bus.key_raw[key] = 1'b1;
        for (int k = 1; k <= total; k++) begin
            @(negedge clk);
            if (k == hold)
                bus.key_raw[key] = 1'b0;
            if (bus.key_pulse[key])
                pt.push_back(k);
            if (fall_at < 0 && k > hold &&
                !bus.key_level[key])
                fall_at = k;
        end
    endtask

    initial begin
        logic seen;
        reset = 1'b0;
        clear = 1'b0;
        bus.key_raw = 4'hF;

        // Reset held with all keys down.
        repeat (3) @(negedge clk);
        check("rst_level", 32'(bus.key_level), 0);
        check("rst_pulse", 32'(bus.key_pulse), 0);
        check("rst_any", 32'(bus.any_pulse), 0);
        reset = 1'b1;
        repeat (5) @(negedge clk);
        check("t1_lvl_e5", 32'(bus.key_level), 0);
        @(negedge clk);
        check("t1_lvl_e6", 32'(bus.key_level), 32'hF);
        check("t1_pls_e6", 32'(bus.key_pulse), 32'hF);
        check("t1_any_e6", 32'(bus.any_pulse), 1);
        @(negedge clk);
        check("t1_pls_e7", 32'(bus.key_pulse), 0);
        check("t1_any_e7", 32'(bus.any_pulse), 0);
        bus.key_raw = 4'h0;
        repeat (15) @(negedge clk);
        check("t1_rel", 32'(bus.key_level), 0);

        // Short glitch.
        seen = 1'b0;
        bus.key_raw = 4'b0001;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (k == 3)
                bus.key_raw = 4'b0000;
            seen = seen | bus.key_level[0] |
                   bus.key_pulse[0];
        end
        check("t2_glitch", 32'(seen), 0);

        // Held repeat key.
        hold_key(0, 40, 55);
        check("t3_npulse", pt.size(), 11);
        check("t3_press", pt_at(0), 6);
        check("t3_rep1", pt_at(1), 16);
        check("t3_rep2", pt_at(2), 19);
        check("t3_last", pt_at(10), 43);
        check("t3_fall", fall_at, 46);

        // Press-only key.
        hold_key(2, 40, 55);
        check("t4_npulse", pt.size(), 1);
        check("t4_press", pt_at(0), 6);
        check("t4_fall", fall_at, 46);

        // Release lands on a due repeat.
        hold_key(1, 13, 30);
        check("t5_npulse", pt.size(), 2);
        check("t5_rep1", pt_at(1), 16);
        check("t5_fall", fall_at, 19);
        hold_key(1, 12, 25);
        check("t5_repress", pt_at(0), 6);

        // Clear while repeating.
        bus.key_raw[3] = 1'b1;
        repeat (20) @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        check("t6_lvl", 32'(bus.key_level), 0);
        check("t6_pls", 32'(bus.key_pulse), 0);
        check("t6_any", 32'(bus.any_pulse), 0);
        pt.delete();
        for (int k = 22; k <= 40; k++) begin
            @(negedge clk);
            if (bus.key_pulse[3])
                pt.push_back(k);
        end
        check("t6_press", pt_at(0), 27);
        check("t6_rep1", pt_at(1), 37);

        // Asynchronous reset while repeating.
        reset = 1'b0;
        #1;
        check("t7_async", 32'(bus.key_level), 0);
        @(negedge clk);
        reset = 1'b1;
        pt.delete();
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (bus.key_pulse[3])
                pt.push_back(k);
        end
        check("t7_press", pt_at(0), 6);
        bus.key_raw = 4'h0;
        repeat (12) @(negedge clk);

        // Random traffic with occasional clear and reset.
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if ($urandom_range(0, 15) == 0)
                bus.key_raw[$urandom_range(0, N-1)] ^= 1'b1;
            clear = ($urandom_range(0, 299) == 0);
            reset = ($urandom_range(0, 499) != 0);
        end
        @(negedge clk);
        reset = 1'b1;
        clear = 1'b0;
        repeat (5) @(negedge clk);

        $display("Result: errors=%0d of %0d checks",
                 errors, checks);
        $finish;
    end
endmodule
